// File: rtl/calc_unit_sequencer.sv
// calc_unit_sequencer
//   Loop sequencer in front of a calc_unit_parallel array. After start it walks
//   output channels (outer), pixels, then input channels (inner). Each beat it
//   presents the in_buf/kn_buf read addresses. It also delays the calc-unit
//   controls so they meet the buffer read data, and delays the out_buf write
//   so it meets the accumulated result.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, hold         run request (sampled in IDLE), beat-issue stall
//   cfg_ic/pix/oc       loop counts (0 in any count means nothing to do)
//   cfg_*_base          base addresses for in_buf, kn_buf, out_buf
//   in_buf_raddr        input-buffer read address (shared by both bit planes)
//   kn_buf_raddr        kernel-buffer read address
//   calc_en/we/reset    calc-unit controls, aligned with buffer read data
//   out_waddr, out_we   out_buf write, aligned with the calc result
//   busy, done          run in progress, one-cycle completion pulse
//
// Optional build macro CALC_SEQ_PERF_EN adds perf_cycles / perf_stalls
// (saturating 32-bit counters of busy cycles and held RUN cycles).

module calc_unit_sequencer #(
   parameter int ADDR_WIDTH   = 16,
   parameter int CNT_WIDTH    = 12,
   parameter int BUF_LATENCY  = 1,
   parameter int CALC_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  hold,
   input  logic [CNT_WIDTH-1:0]  cfg_ic,
   input  logic [CNT_WIDTH-1:0]  cfg_pix,
   input  logic [CNT_WIDTH-1:0]  cfg_oc,
   input  logic [ADDR_WIDTH-1:0] cfg_in_base,
   input  logic [ADDR_WIDTH-1:0] cfg_kn_base,
   input  logic [ADDR_WIDTH-1:0] cfg_out_base,
   output logic [ADDR_WIDTH-1:0] in_buf_raddr,
   output logic [ADDR_WIDTH-1:0] kn_buf_raddr,
   output logic                  calc_en,
   output logic                  calc_we,
   output logic                  calc_reset,
   output logic [ADDR_WIDTH-1:0] out_waddr,
   output logic                  out_we,
   output logic                  busy,
   output logic                  done
`ifdef CALC_SEQ_PERF_EN
   ,
   output logic [31:0]           perf_cycles,
   output logic [31:0]           perf_stalls
`endif
);

   localparam int DEPTH   = BUF_LATENCY + CALC_LATENCY;
   localparam int DRAIN_W = $clog2(DEPTH + 1);
   localparam int OUT_N   = (CALC_LATENCY > 0) ? CALC_LATENCY : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic                  en;
      logic                  we;
      logic                  rst;
      logic [ADDR_WIDTH-1:0] waddr;
   } tag_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] waddr;
   } wr_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cfg_ic_q, cfg_pix_q, cfg_oc_q;
   logic [CNT_WIDTH-1:0]  ic_q, pix_q, oc_q;
   logic [ADDR_WIDTH-1:0] in_base_q;
   logic [ADDR_WIDTH-1:0] in_addr_q, kn_addr_q, kn_row_q, out_addr_q;
   logic [DRAIN_W-1:0]    drain_q;

   logic cfg_zero, beat, last_ic, last_pix, last_oc;
   tag_t tag_d;
   tag_t ctl_q [BUF_LATENCY];
   wr_t  wr_q  [OUT_N];

   assign cfg_zero = (cfg_ic == '0) || (cfg_pix == '0) || (cfg_oc == '0);
   assign last_ic  = (ic_q  == cfg_ic_q  - CNT_WIDTH'(1));
   assign last_pix = (pix_q == cfg_pix_q - CNT_WIDTH'(1));
   assign last_oc  = (oc_q  == cfg_oc_q  - CNT_WIDTH'(1));
   assign beat     = (state_q == S_RUN) && !hold;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tag_d   = '0;
      if (beat) begin
         tag_d.en    = 1'b1;
         tag_d.rst   = (ic_q == '0);
         tag_d.we    = last_ic;
         tag_d.waddr = last_ic ? out_addr_q : '0;
      end
      case (state_q)
         S_IDLE:  if (start) state_d = cfg_zero ? S_DONE : S_RUN;
         S_RUN:   if (beat && last_ic && last_pix && last_oc) state_d = S_DRAIN;
         S_DRAIN: if (drain_q == DRAIN_W'(DEPTH - 1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ loop counters
   // Addresses are tracked incrementally:
   //   in  : consecutive within one oc, rewinds to base when oc advances.
   //   kn  : consecutive within one pixel, rewinds to the oc row start at the
   //         end of each pixel; the row start steps by cfg_ic per oc.
   //   out : consecutive over all we beats.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_ic_q   <= '0;
         cfg_pix_q  <= '0;
         cfg_oc_q   <= '0;
         ic_q       <= '0;
         pix_q      <= '0;
         oc_q       <= '0;
         in_base_q  <= '0;
         in_addr_q  <= '0;
         kn_addr_q  <= '0;
         kn_row_q   <= '0;
         out_addr_q <= '0;
         drain_q    <= '0;
      end else begin
         drain_q <= (state_q == S_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
         if (state_q == S_IDLE && start) begin
            cfg_ic_q   <= cfg_ic;
            cfg_pix_q  <= cfg_pix;
            cfg_oc_q   <= cfg_oc;
            ic_q       <= '0;
            pix_q      <= '0;
            oc_q       <= '0;
            in_base_q  <= cfg_in_base;
            in_addr_q  <= cfg_in_base;
            kn_addr_q  <= cfg_kn_base;
            kn_row_q   <= cfg_kn_base;
            out_addr_q <= cfg_out_base;
         end else if (beat) begin
            if (!last_ic) begin
               ic_q      <= ic_q + CNT_WIDTH'(1);
               in_addr_q <= in_addr_q + ADDR_WIDTH'(1);
               kn_addr_q <= kn_addr_q + ADDR_WIDTH'(1);
            end else begin
               ic_q       <= '0;
               out_addr_q <= out_addr_q + ADDR_WIDTH'(1);
               if (!last_pix) begin
                  pix_q     <= pix_q + CNT_WIDTH'(1);
                  in_addr_q <= in_addr_q + ADDR_WIDTH'(1);
                  kn_addr_q <= kn_row_q;
               end else begin
                  pix_q     <= '0;
                  oc_q      <= oc_q + CNT_WIDTH'(1);
                  in_addr_q <= in_base_q;
                  kn_addr_q <= kn_addr_q + ADDR_WIDTH'(1);
                  kn_row_q  <= kn_addr_q + ADDR_WIDTH'(1);
               end
            end
         end
      end
   end

   // ------------------------------------------------------- tag pipeline
   // Never stalls: a held cycle simply inserts an all-zero tag.
   for (genvar gi = 0; gi < BUF_LATENCY; gi++) begin : g_ctl
      always_ff @(posedge clk) begin
         if (!rst_n)       ctl_q[gi] <= '0;
         else if (gi == 0) ctl_q[gi] <= tag_d;
         else              ctl_q[gi] <= ctl_q[(gi > 0) ? gi - 1 : 0];
      end
   end

   if (CALC_LATENCY > 0) begin : g_wr
      for (genvar gi = 0; gi < CALC_LATENCY; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               wr_q[gi] <= '0;
            end else if (gi == 0) begin
               wr_q[gi].we    <= ctl_q[BUF_LATENCY-1].we;
               wr_q[gi].waddr <= ctl_q[BUF_LATENCY-1].waddr;
            end else begin
               wr_q[gi] <= wr_q[(gi > 0) ? gi - 1 : 0];
            end
         end
      end
      assign out_we    = wr_q[CALC_LATENCY-1].we;
      assign out_waddr = wr_q[CALC_LATENCY-1].waddr;
   end else begin : g_nowr
      assign wr_q[0]   = '0;
      assign out_we    = ctl_q[BUF_LATENCY-1].we;
      assign out_waddr = ctl_q[BUF_LATENCY-1].waddr;
   end

   assign calc_en      = ctl_q[BUF_LATENCY-1].en;
   assign calc_we      = ctl_q[BUF_LATENCY-1].we;
   assign calc_reset   = ctl_q[BUF_LATENCY-1].rst;
   assign in_buf_raddr = (state_q == S_RUN) ? in_addr_q : '0;
   assign kn_buf_raddr = (state_q == S_RUN) ? kn_addr_q : '0;
   assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE);

`ifdef CALC_SEQ_PERF_EN
   logic [31:0] perf_cycles_q, perf_stalls_q;

   always_ff @(posedge clk) begin
      if (!rst_n || (state_q == S_IDLE && start)) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         if (busy && perf_cycles_q != '1)
            perf_cycles_q <= perf_cycles_q + 32'd1;
         if (state_q == S_RUN && hold && perf_stalls_q != '1)
            perf_stalls_q <= perf_stalls_q + 32'd1;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: doc/calc_unit_sequencer.md
# calc_unit_sequencer

Control sequencer that feeds a `calc_unit_parallel` array. After a `start` pulse it walks the output-channel, pixel and input-channel loops. Each step it drives the read addresses of the input buffer (both bit-plane banks share one address) and of the kernel buffer. It delays the calc-unit controls (`en`, `we`, `reset`) so they arrive in the same cycle as the buffer read data, and it emits the out_buf write address/strobe aligned with the calc unit's accumulated result. It sits between the layer-level controller and the buffer/calc-unit datapath.

## Interface
- `ADDR_WIDTH`, 16: width of all buffer addresses.
- `CNT_WIDTH`, 12: width of each loop-count config field.
- `BUF_LATENCY`, 1: read latency of in_buf/kn_buf in cycles (≥1).
- `CALC_LATENCY`, 2: cycles from calc `we` (with rdata) to result registered in the calc unit.

- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `hold`  in  1  stall request; no new beat is issued while high.
- `cfg_ic`  in  CNT_WIDTH  input-channel words per pixel.
- `cfg_pix`  in  CNT_WIDTH  pixels per output channel.
- `cfg_oc`  in  CNT_WIDTH  output-channel groups.
- `cfg_in_base`, `cfg_kn_base`, `cfg_out_base`  in  ADDR_WIDTH  base addresses.
- `in_buf_raddr`  out  ADDR_WIDTH  input-buffer read address (both banks).
- `kn_buf_raddr`  out  ADDR_WIDTH  kernel-buffer read address.
- `calc_en`, `calc_we`, `calc_reset`  out  1  calc-unit controls, aligned with rdata.
- `out_waddr`  out  ADDR_WIDTH  out_buf write address.
- `out_we`  out  1  one-cycle write strobe for out_buf.
- `busy`  out  1  high from the first RUN cycle until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - When `start`=1, latch all cfg fields.
  - If any count is 0, go to DONE (no beats are issued). Otherwise go to RUN.
  - `start` outside IDLE is ignored.
- RUN:
  - Each cycle with `hold`=0 issues one beat. The loop order is oc (outer), pix, ic (inner).
  - `in_buf_raddr` = `cfg_in_base` + pix·cfg_ic + ic.
  - `kn_buf_raddr` = `cfg_kn_base` + oc·cfg_ic + ic.
  - Addresses come from running counters, not multipliers, and wrap modulo 2^ADDR_WIDTH.
  - Beat tag: en=1, reset=(ic==0), we=(ic==cfg_ic−1); on a we beat, waddr = `cfg_out_base` + oc·cfg_pix + pix.
  - A cycle with `hold`=1 issues a bubble: tag all zero, counters and addresses frozen.
  - After the beat for (oc=cfg_oc−1, pix=cfg_pix−1, ic=cfg_ic−1), go to DRAIN.
- Tag pipeline:
  - Delay line of depth BUF_LATENCY drives `calc_en`/`calc_we`/`calc_reset`. Bubbles propagate as zeros.
  - A further CALC_LATENCY stages carry we/waddr to `out_we`/`out_waddr`.
  - The pipeline always advances; `hold` does not stall it.
- DRAIN: wait until the pipeline is empty (BUF_LATENCY+CALC_LATENCY cycles), then go to DONE.
- DONE: pulse `done` for one cycle, with `busy`=0, then return to IDLE.
- Total beats issued = cfg_ic·cfg_pix·cfg_oc. Total `out_we` pulses = cfg_pix·cfg_oc, in ascending waddr order.

## Timing
- Reset values: state IDLE; all outputs 0; pipeline cleared.
- `rst_n`=0 mid-operation: on the next edge, return to IDLE with all outputs 0. In-flight `out_we` pulses are discarded.
- With `start` sampled at the edge ending cycle 0:
  - First address appears in cycle 1, and `busy` goes high in cycle 1.
  - That beat's controls appear in cycle 1+BUF_LATENCY.
  - Its `out_we` (if it is a we beat) appears in cycle 1+BUF_LATENCY+CALC_LATENCY.
- `done` is asserted the cycle after the final `out_we`. `busy` is low in the `done` cycle.
- Zero-count config: `done` in cycle 1, `busy` never rises.
- `hold` high in the same cycle as `start`: the transition to RUN still occurs, but beat issue waits for `hold`=0.

## Configuration
- `CALC_SEQ_PERF_EN` defined:
  - Adds outputs `perf_cycles` (32 b, cycles with `busy`=1) and `perf_stalls` (32 b, RUN cycles with `hold`=1).
  - Both clear on `start` acceptance and on reset, and saturate at 2^32−1.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single beat: BUF_LATENCY=1, ic=pix=oc=1, bases 0 → addresses 0/0 in cycle 1; en=we=reset=1 in cycle 2; `out_we` with waddr 0 in cycle 4; `done` in cycle 5.
- ic=3, pix=2, oc=2, bases in=0x10/kn=0x20/out=0x40:
  - in addr sequence 10,11,12,13,14,15, repeated.
  - kn addr 20,21,22 ×2 then 23,24,25 ×2.
  - `calc_reset` on beats 0,3,6,9.
  - `out_we` ×4 with waddr 40,41,42,43.
- `hold` high for cycles 2–4 of the run above → addresses frozen and controls zero during those beats; the order is unchanged; `done` slips by exactly 3 cycles.
- `rst_n` low at beat 5 of the run above → next cycle all outputs 0 and state IDLE; no further `out_we`; a fresh `start` reruns the full sequence.
- cfg_pix=0 → `done` in cycle 1, no addresses, no `out_we`. `start` pulses while `busy` → ignored and the sequence is unchanged.
- With `CALC_SEQ_PERF_EN`, the hold scenario → `perf_stalls`=3, `perf_cycles` = cycles from `busy` rise to fall.
